// File: rtl/pc_call_stack_unit.sv
//------------------------------------------------------------------------------
// Module      : pc_call_stack_unit
// Description : Program counter with a hardware return-address stack (CALL/RET),
//               sticky overflow/underflow flags. Optional macro PC_REL_BRANCH_EN
//               adds a signed 8-bit relative branch (requires ADDR_WIDTH >= 8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_call_stack_unit #(
   parameter int ADDR_WIDTH  = 12,
   parameter int STACK_DEPTH = 4,
   localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pc_inc,
   input  logic                  pc_write_enable,
   input  logic                  pc_call,
   input  logic                  pc_ret,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   input  logic                  err_clear,
`ifdef PC_REL_BRANCH_EN
   input  logic                  pc_rel_enable,
   input  logic [7:0]            pc_rel_offset,
`endif
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [DEPTH_W-1:0]    stack_depth,
   output logic                  stack_full,
   output logic                  stack_empty,
   output logic                  stack_overflow,
   output logic                  stack_underflow
);

   localparam int IDX_W = $clog2(STACK_DEPTH);

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [DEPTH_W-1:0]    r_depth;
   logic                  r_overflow;
   logic                  r_underflow;
   logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

   logic                  w_full;
   logic                  w_empty;
   logic [IDX_W-1:0]      w_push_idx;
   logic [IDX_W-1:0]      w_pop_idx;
   logic                  w_push;

   assign w_full     = (r_depth == DEPTH_W'(STACK_DEPTH));
   assign w_empty    = (r_depth == '0);
   // Indices are only used when the stack is not full (push) / not empty (pop).
   assign w_push_idx = r_depth[IDX_W-1:0];
   assign w_pop_idx  = IDX_W'(r_depth - DEPTH_W'(1));
   assign w_push     = reset_n && pc_call && !pc_ret && !w_full;

`ifdef PC_REL_BRANCH_EN
   logic [ADDR_WIDTH-1:0] w_rel_ext;
   assign w_rel_ext = {{(ADDR_WIDTH-8){pc_rel_offset[7]}}, pc_rel_offset};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc        <= '0;
         r_depth     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         // Clear first; an error raised in the same cycle overrides below.
         r_overflow  <= r_overflow  & ~err_clear;
         r_underflow <= r_underflow & ~err_clear;
         if (pc_ret) begin
            if (w_empty) begin
               r_underflow <= 1'b1;
            end else begin
               r_pc    <= r_stack[w_pop_idx];
               r_depth <= r_depth - DEPTH_W'(1);
            end
         end else if (pc_call) begin
            if (w_full) begin
               r_overflow <= 1'b1;
            end else begin
               r_pc    <= pc_in;
               r_depth <= r_depth + DEPTH_W'(1);
            end
         end else if (pc_write_enable) begin
            r_pc <= pc_in;
`ifdef PC_REL_BRANCH_EN
         end else if (pc_rel_enable) begin
            r_pc <= r_pc + w_rel_ext;
`endif
         end else if (pc_inc) begin
            r_pc <= r_pc + ADDR_WIDTH'(1);
         end
      end
   end

   // Stack storage carries no reset; an empty stack is never read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_stack[w_push_idx] <= r_pc;
      end
   end

   assign pc_out          = r_pc;
   assign stack_depth     = r_depth;
   assign stack_full      = w_full;
   assign stack_empty     = w_empty;
   assign stack_overflow  = r_overflow;
   assign stack_underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_pc_call_stack_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_pc_call_stack_unit
// Description : Directed self-checking bench for pc_call_stack_unit (12-bit, depth 4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_call_stack_unit;

   logic        clk;
   logic        reset_n;
   logic        pc_inc;
   logic        pc_write_enable;
   logic        pc_call;
   logic        pc_ret;
   logic [11:0] pc_in;
   logic        err_clear;
`ifdef PC_REL_BRANCH_EN
   logic        pc_rel_enable;
   logic [7:0]  pc_rel_offset;
`endif
   logic [11:0] pc_out;
   logic [2:0]  stack_depth;
   logic        stack_full;
   logic        stack_empty;
   logic        stack_overflow;
   logic        stack_underflow;

   int checks   = 0;
   int failures = 0;

   pc_call_stack_unit #(.ADDR_WIDTH(12), .STACK_DEPTH(4)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .pc_inc          (pc_inc),
      .pc_write_enable (pc_write_enable),
      .pc_call         (pc_call),
      .pc_ret          (pc_ret),
      .pc_in           (pc_in),
      .err_clear       (err_clear),
`ifdef PC_REL_BRANCH_EN
      .pc_rel_enable   (pc_rel_enable),
      .pc_rel_offset   (pc_rel_offset),
`endif
      .pc_out          (pc_out),
      .stack_depth     (stack_depth),
      .stack_full      (stack_full),
      .stack_empty     (stack_empty),
      .stack_overflow  (stack_overflow),
      .stack_underflow (stack_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock with the given command; inputs return to idle afterwards.
   task automatic cmd(input logic inc, input logic we, input logic call, input logic ret,
                      input logic [11:0] pin, input logic clr);
      pc_inc = inc; pc_write_enable = we; pc_call = call; pc_ret = ret;
      pc_in = pin; err_clear = clr;
      @(posedge clk); #1;
      pc_inc = 0; pc_write_enable = 0; pc_call = 0; pc_ret = 0; err_clear = 0;
   endtask

   initial begin
      reset_n = 0; pc_inc = 0; pc_write_enable = 0; pc_call = 0; pc_ret = 0;
      pc_in = '0; err_clear = 0;
`ifdef PC_REL_BRANCH_EN
      pc_rel_enable = 0; pc_rel_offset = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_pc",    pc_out, 0);
      check_val("rst_depth", stack_depth, 0);
      check_val("rst_empty", stack_empty, 1);
      check_val("rst_full",  stack_full, 0);
      check_val("rst_ovf",   stack_overflow, 0);
      check_val("rst_unf",   stack_underflow, 0);
      @(negedge clk); reset_n = 1;

      // Increment
      repeat (3) cmd(1, 0, 0, 0, 12'h000, 0);
      check_val("inc3_pc",    pc_out, 12'h003);
      check_val("inc3_empty", stack_empty, 1);

      // Single call / return
      cmd(0, 0, 1, 0, 12'h123, 0);
      check_val("call_pc",    pc_out, 12'h123);
      check_val("call_depth", stack_depth, 1);
      cmd(0, 0, 0, 1, 12'h000, 0);
      check_val("ret_pc",    pc_out, 12'h003);
      check_val("ret_depth", stack_depth, 0);

      // Fill stack, overflow, unwind in LIFO order
      cmd(0, 0, 1, 0, 12'h100, 0);
      cmd(0, 0, 1, 0, 12'h200, 0);
      cmd(0, 0, 1, 0, 12'h300, 0);
      cmd(0, 0, 1, 0, 12'h400, 0);
      check_val("fill_full",  stack_full, 1);
      check_val("fill_depth", stack_depth, 4);
      cmd(0, 0, 1, 0, 12'h7FF, 0);
      check_val("ovf_pc",    pc_out, 12'h400);
      check_val("ovf_depth", stack_depth, 4);
      check_val("ovf_flag",  stack_overflow, 1);
      cmd(0, 0, 0, 1, 12'h000, 0);
      check_val("pop1", pc_out, 12'h300);
      cmd(0, 0, 0, 1, 12'h000, 0);
      check_val("pop2", pc_out, 12'h200);
      cmd(0, 0, 0, 1, 12'h000, 0);
      check_val("pop3", pc_out, 12'h100);
      cmd(0, 0, 0, 1, 12'h000, 0);
      check_val("pop4",       pc_out, 12'h003);
      check_val("pop4_empty", stack_empty, 1);
      check_val("ovf_sticky", stack_overflow, 1);
      cmd(0, 0, 0, 0, 12'h000, 1);
      check_val("ovf_clear", stack_overflow, 0);

      // Underflow, set-wins over clear, then clear
      cmd(0, 1, 0, 0, 12'h050, 0);
      cmd(0, 0, 0, 1, 12'h000, 0);
      check_val("unf_pc",   pc_out, 12'h050);
      check_val("unf_flag", stack_underflow, 1);
      cmd(0, 0, 0, 1, 12'h000, 1);
      check_val("unf_setwins", stack_underflow, 1);
      cmd(0, 0, 0, 0, 12'h000, 1);
      check_val("unf_clear", stack_underflow, 0);

      // Priority: ret over call over inc; write over inc
      cmd(0, 1, 0, 0, 12'h010, 0);
      cmd(0, 0, 1, 0, 12'h999, 0);
      check_val("prio_call_pc", pc_out, 12'h999);
      cmd(1, 0, 1, 1, 12'h555, 0);
      check_val("prio_ret_pc",    pc_out, 12'h010);
      check_val("prio_ret_depth", stack_depth, 0);
      cmd(1, 1, 0, 0, 12'h0AA, 0);
      check_val("prio_we_pc", pc_out, 12'h0AA);
      cmd(0, 1, 0, 0, 12'hFFF, 0);
      cmd(1, 0, 0, 0, 12'h000, 0);
      check_val("inc_wrap", pc_out, 12'h000);

      // Async reset mid-cycle at depth 2
      cmd(0, 0, 1, 0, 12'h300, 0);
      cmd(0, 0, 1, 0, 12'h200, 0);
      check_val("pre_rst_depth", stack_depth, 2);
      check_val("pre_rst_pc",    pc_out, 12'h200);
      #2 reset_n = 0;
      #1;
      check_val("async_pc",    pc_out, 0);
      check_val("async_depth", stack_depth, 0);
      reset_n = 1;

`ifdef PC_REL_BRANCH_EN
      pc_rel_enable = 1; pc_rel_offset = 8'hFE;
      @(posedge clk); #1;
      pc_rel_enable = 0;
      check_val("rel_neg", pc_out, 12'hFFE);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
